csd_decoder: RTL

CSD_DECODER -- requirements
Module: csd_decoder

---
 rtl/csd_pkg.sv | 19 +
 rtl/csd_digit_decode.sv | 31 +++
 rtl/csd_decoder.sv | 119 +++++++++++
 3 files changed

// File: rtl/csd_pkg.sv
// Shared constants for the CSD encoder/decoder datapath.
// Holds the signed-digit word encodings and the decoder FSM state encoding.
package csd_pkg;

    localparam logic [7:0] CSD_ZERO = 8'h00;
    localparam logic [7:0] CSD_POS  = 8'h01;
    localparam logic [7:0] CSD_NEG  = 8'hFF;

    localparam int unsigned VALUE_W = 17;
    localparam int unsigned COUNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } csdState_t;

endpackage

// File: rtl/csd_digit_decode.sv
// Combinational classification of one CSD digit word into nonzero/negative/invalid.
module csd_digit_decode
    import csd_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] digit,
    output logic              nonzero,
    output logic              negative,
    output logic              invalid
);

    localparam logic [DATA_W-1:0] ZeroW = DATA_W'(CSD_ZERO);
    localparam logic [DATA_W-1:0] PosW  = DATA_W'(CSD_POS);
    localparam logic [DATA_W-1:0] NegW  = DATA_W'(CSD_NEG);

    always_comb begin
        nonzero  = 1'b0;
        negative = 1'b0;
        invalid  = 1'b0;
        if (digit == PosW) begin
            nonzero = 1'b1;
        end else if (digit == NegW) begin
            nonzero  = 1'b1;
            negative = 1'b1;
        end else if (digit != ZeroW) begin
            invalid = 1'b1;
        end
    end

endmodule

// File: rtl/csd_decoder.sv
// Reads N_DIGITS CSD digits from an external memory (LSB first) and rebuilds the
// signed binary value, counting nonzero digits and flagging malformed input.
module csd_decoder
    import csd_pkg::*;
#(
    parameter int unsigned N_DIGITS = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 mem_re,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 busy,
    output logic                 done,
    output logic [VALUE_W-1:0]   value,
    output logic [COUNT_W-1:0]   nz_count,
    output logic                 err_digit,
    output logic                 err_adj
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N_DIGITS - 1);

    csdState_t          state;
    logic [ADDR_W-1:0]  index;
    logic               prevNz;
    logic               digNz;
    logic               digNeg;
    logic               digInv;
    logic [VALUE_W-1:0] weight;
    logic [VALUE_W-1:0] addend;

    csd_digit_decode #(
        .DATA_W (DATA_W)
    ) uDigitDecode (
        .digit    (mem_data),
        .nonzero  (digNz),
        .negative (digNeg),
        .invalid  (digInv)
    );

    // Signed contribution of the digit at the current index; invalid words add 0.
    always_comb begin
        weight = VALUE_W'(1) << index;
        addend = '0;
        if (digNz) begin
            addend = digNeg ? (VALUE_W'(0) - weight) : weight;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            index     <= '0;
            prevNz    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            value     <= '0;
            nz_count  <= '0;
            err_digit <= 1'b0;
            err_adj   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        value     <= '0;
                        nz_count  <= '0;
                        err_digit <= 1'b0;
                        err_adj   <= 1'b0;
                        index     <= '0;
                        prevNz    <= 1'b0;
                        busy      <= 1'b1;
                        mem_re    <= 1'b1;
                        mem_addr  <= '0;
                        state     <= RD;
                    end
                end
                RD: begin
                    mem_re <= 1'b0;
                    state  <= ACC;
                end
                ACC: begin
                    value  <= value + addend;
                    prevNz <= digNz;
                    if (digNz) begin
                        nz_count <= nz_count + COUNT_W'(1);
                    end
                    if (digInv) begin
                        err_digit <= 1'b1;
                    end
                    // Digit 0 has no lower neighbour, so prevNz is ignored there.
                    if (digNz && prevNz && (index != '0)) begin
                        err_adj <= 1'b1;
                    end
                    if (index == LastIdx) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        index    <= index + 1'b1;
                        mem_re   <= 1'b1;
                        mem_addr <= index + 1'b1;
                        state    <= RD;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
